// File: rtl/mkii_bus_sequencer_if.sv
`default_nettype none
// ============================================================================
// mkii_bus_sequencer_if : instruction handshake plus shared-bus control lines
// Revision: 1.0
// ============================================================================
interface mkii_bus_sequencer_if #(
   parameter int XLEN  = 32,
   parameter int RF_AW = 5
);
   logic             instr_valid;
   logic [XLEN-1:0]  instr;
   logic             instr_ready;
   logic [1:0]       bus_src_sel;
   logic [RF_AW-1:0] rf_raddr;
   logic [RF_AW-1:0] rf_waddr;
   logic             rf_we;
   logic             alu_a_load;
   logic             alu_b_load;
   logic [3:0]       alu_op;
   logic [XLEN-1:0]  imm_out;
   logic             busy;
   logic             done;
   logic             illegal;

   // Sequencer side
   modport master (
      input  instr_valid, instr,
      output instr_ready, bus_src_sel, rf_raddr, rf_waddr, rf_we,
             alu_a_load, alu_b_load, alu_op, imm_out, busy, done, illegal
   );

   // Instruction source / datapath side
   modport slave (
      output instr_valid, instr,
      input  instr_ready, bus_src_sel, rf_raddr, rf_waddr, rf_we,
             alu_a_load, alu_b_load, alu_op, imm_out, busy, done, illegal
   );
endinterface
`default_nettype wire

// File: rtl/mkii_bus_sequencer.sv
`default_nettype none
// ============================================================================
// mkii_bus_sequencer : multi-cycle shared-bus control sequencer (OP/OP-IMM/LUI)
// Optional counters under macro MKII_SEQ_PERF_EN.   Revision: 1.0
// ============================================================================
module mkii_bus_sequencer #(
   parameter int XLEN  = 32,
   parameter int RF_AW = 5
) (
   input  wire logic            clk,
   input  wire logic            reset,
   mkii_bus_sequencer_if.master bus
`ifdef MKII_SEQ_PERF_EN
   ,
   output logic [31:0]          retired_cnt,
   output logic [31:0]          illegal_cnt
`endif
);

   localparam logic [2:0] c_st_idle = 3'd0;
   localparam logic [2:0] c_st_rd_a = 3'd1;
   localparam logic [2:0] c_st_rd_b = 3'd2;
   localparam logic [2:0] c_st_exec = 3'd3;
   localparam logic [2:0] c_st_wb   = 3'd4;
   localparam logic [2:0] c_st_err  = 3'd5;

   localparam logic [6:0] c_opc_op_imm = 7'b0010011;
   localparam logic [6:0] c_opc_op     = 7'b0110011;
   localparam logic [6:0] c_opc_lui    = 7'b0110111;

   localparam logic [1:0] c_src_none = 2'd0;
   localparam logic [1:0] c_src_rf   = 2'd1;
   localparam logic [1:0] c_src_imm  = 2'd2;
   localparam logic [1:0] c_src_alu  = 2'd3;

   logic [2:0]       r_state;
   logic [2:0]       w_next_state;
   logic [XLEN-1:0]  r_instr;
   logic             w_accept;
   logic             w_in_legal;
   logic             w_is_op;
   logic             w_is_op_imm;
   logic             w_is_lui;
   logic [2:0]       w_funct3;
   logic [RF_AW-1:0] w_rs1;
   logic [RF_AW-1:0] w_rs2;
   logic [RF_AW-1:0] w_rd;
   logic [3:0]       w_alu_op;
   logic [31:0]      w_imm32;

   // Legality is judged on the offered word; everything else uses the latch.
   assign w_in_legal = (bus.instr[6:0] == c_opc_op_imm) ||
                       (bus.instr[6:0] == c_opc_op)     ||
                       (bus.instr[6:0] == c_opc_lui);
   assign w_accept   = (r_state == c_st_idle) && bus.instr_valid;

   assign w_is_op     = (r_instr[6:0] == c_opc_op);
   assign w_is_op_imm = (r_instr[6:0] == c_opc_op_imm);
   assign w_is_lui    = (r_instr[6:0] == c_opc_lui);
   assign w_funct3    = r_instr[14:12];
   assign w_rs1       = RF_AW'(r_instr[19:15]);
   assign w_rs2       = RF_AW'(r_instr[24:20]);
   assign w_rd        = RF_AW'(r_instr[11:7]);

   // Only shifts distinguish arithmetic/logical via bit 30 in OP-IMM.
   always_comb begin
      w_alu_op = 4'b0000;
      if (w_is_op) begin
         w_alu_op = {r_instr[30], w_funct3};
      end else if (w_is_op_imm) begin
         w_alu_op = {(w_funct3 == 3'b101) & r_instr[30], w_funct3};
      end
   end

   always_comb begin
      w_imm32 = 32'd0;
      if (w_is_op_imm) begin
         w_imm32 = {{20{r_instr[31]}}, r_instr[31:20]};
      end else if (w_is_lui) begin
         w_imm32 = {r_instr[31:12], 12'd0};
      end
   end

   assign bus.imm_out = XLEN'($signed(w_imm32));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= c_st_idle;
         r_instr <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_accept) begin
            r_instr <= bus.instr;
         end
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_st_idle: begin
            if (bus.instr_valid) begin
               w_next_state = w_in_legal ? c_st_rd_a : c_st_err;
            end
         end
         c_st_rd_a: w_next_state = c_st_rd_b;
         c_st_rd_b: w_next_state = c_st_exec;
         c_st_exec: w_next_state = c_st_wb;
         c_st_wb:   w_next_state = c_st_idle;
         c_st_err:  w_next_state = c_st_idle;
         default:   w_next_state = c_st_idle;
      endcase
   end

   always_comb begin
      bus.instr_ready = 1'b0;
      bus.busy        = 1'b1;
      bus.bus_src_sel = c_src_none;
      bus.rf_raddr    = '0;
      bus.rf_waddr    = '0;
      bus.rf_we       = 1'b0;
      bus.alu_a_load  = 1'b0;
      bus.alu_b_load  = 1'b0;
      bus.alu_op      = 4'b0000;
      bus.done        = 1'b0;
      bus.illegal     = 1'b0;
      case (r_state)
         c_st_idle: begin
            bus.instr_ready = 1'b1;
            bus.busy        = 1'b0;
         end
         c_st_rd_a: begin
            bus.bus_src_sel = c_src_rf;
            bus.rf_raddr    = w_is_lui ? '0 : w_rs1;
            bus.alu_a_load  = 1'b1;
         end
         c_st_rd_b: begin
            if (w_is_op) begin
               bus.bus_src_sel = c_src_rf;
               bus.rf_raddr    = w_rs2;
            end else begin
               bus.bus_src_sel = c_src_imm;
            end
            bus.alu_b_load = 1'b1;
         end
         c_st_exec: begin
            bus.alu_op = w_alu_op;
         end
         c_st_wb: begin
            bus.bus_src_sel = c_src_alu;
            bus.rf_waddr    = w_rd;
            bus.rf_we       = (w_rd != '0);
            bus.alu_op      = w_alu_op;
            bus.done        = 1'b1;
         end
         c_st_err: begin
            bus.illegal = 1'b1;
         end
         default: begin
            bus.busy = 1'b1;
         end
      endcase
   end

`ifdef MKII_SEQ_PERF_EN
   logic [31:0] r_retired_cnt;
   logic [31:0] r_illegal_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_retired_cnt <= 32'd0;
         r_illegal_cnt <= 32'd0;
      end else begin
         if (r_state == c_st_wb) begin
            r_retired_cnt <= r_retired_cnt + 32'd1;
         end
         if (r_state == c_st_err) begin
            r_illegal_cnt <= r_illegal_cnt + 32'd1;
         end
      end
   end

   assign retired_cnt = r_retired_cnt;
   assign illegal_cnt = r_illegal_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mkii_bus_sequencer.sv
`default_nettype none
// ============================================================================
// tb_mkii_bus_sequencer : directed + random checks against a bus-step model
// Revision: 1.0
// ============================================================================
module tb_mkii_bus_sequencer;

   typedef struct packed {
      logic        ready;
      logic        busy;
      logic [1:0]  src;
      logic [4:0]  raddr;
      logic [4:0]  waddr;
      logic        we;
      logic        a_load;
      logic        b_load;
      logic [3:0]  op;
      logic [31:0] imm;
      logic        done;
      logic        illegal;
   } obs_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   mkii_bus_sequencer_if #(.XLEN(32), .RF_AW(5)) bus ();

`ifdef MKII_SEQ_PERF_EN
   logic [31:0] retired_cnt;
   logic [31:0] illegal_cnt;
`endif

   mkii_bus_sequencer #(.XLEN(32), .RF_AW(5)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef MKII_SEQ_PERF_EN
      ,
      .retired_cnt (retired_cnt),
      .illegal_cnt (illegal_cnt)
`endif
   );

   int          total = 0;
   int          passed = 0;
   int          exp_retired = 0;
   int          exp_illegal = 0;
   logic [31:0] last_ins = 32'd0;

   function automatic bit is_legal(input logic [31:0] ins);
      return (ins[6:0] == 7'h13) || (ins[6:0] == 7'h33) || (ins[6:0] == 7'h37);
   endfunction

   // Expected bus activity at step k after accept (k=0 means sitting idle).
   function automatic obs_t model(input logic [31:0] ins, input int k);
      obs_t        e;
      bit          is_op, is_imm, is_lui;
      logic [31:0] imm;
      logic [3:0]  op;
      e      = '0;
      is_op  = (ins[6:0] == 7'h33);
      is_imm = (ins[6:0] == 7'h13);
      is_lui = (ins[6:0] == 7'h37);
      imm    = is_imm ? {{20{ins[31]}}, ins[31:20]} :
               is_lui ? {ins[31:12], 12'h000} : 32'h0;
      op     = is_op  ? {ins[30], ins[14:12]} :
               is_imm ? {(ins[14:12] == 3'b101) & ins[30], ins[14:12]} : 4'h0;
      e.imm  = imm;
      if (k == 0) begin
         e.ready = 1'b1;
         return e;
      end
      e.busy = 1'b1;
      if (!is_legal(ins)) begin
         e.illegal = 1'b1;
         return e;
      end
      case (k)
         1: begin
            e.src = 2'd1; e.raddr = is_lui ? 5'd0 : ins[19:15]; e.a_load = 1'b1;
         end
         2: begin
            e.src = is_op ? 2'd1 : 2'd2; e.raddr = is_op ? ins[24:20] : 5'd0; e.b_load = 1'b1;
         end
         3: e.op = op;
         default: begin
            e.src = 2'd3; e.waddr = ins[11:7]; e.we = (ins[11:7] != 5'd0);
            e.op = op; e.done = 1'b1;
         end
      endcase
      return e;
   endfunction

   function automatic obs_t observe();
      obs_t o;
      o.ready   = bus.instr_ready;
      o.busy    = bus.busy;
      o.src     = bus.bus_src_sel;
      o.raddr   = bus.rf_raddr;
      o.waddr   = bus.rf_waddr;
      o.we      = bus.rf_we;
      o.a_load  = bus.alu_a_load;
      o.b_load  = bus.alu_b_load;
      o.op      = bus.alu_op;
      o.imm     = bus.imm_out;
      o.done    = bus.done;
      o.illegal = bus.illegal;
      return o;
   endfunction

   task automatic check(input string tag, input obs_t exp);
      obs_t got;
      got = observe();
      total++;
      assert (got === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_cnt(input string tag);
`ifdef MKII_SEQ_PERF_EN
      total++;
      assert ((retired_cnt === 32'(exp_retired)) && (illegal_cnt === 32'(exp_illegal))) begin
         passed++;
      end else begin
         $error("FAIL %s: observed retired=%0d illegal=%0d expected retired=%0d illegal=%0d",
                tag, retired_cnt, illegal_cnt, exp_retired, exp_illegal);
      end
`else
      if (tag.len() < 0) $display("%s", tag);
`endif
   endtask

   // Walk steps 1..upto after an accept; garbage on the inputs must be ignored.
   task automatic run_steps(input logic [31:0] ins, input int upto);
      int n;
      n = is_legal(ins) ? 4 : 1;
      for (int k = 1; k <= upto; k++) begin
         check($sformatf("ins %h step %0d", ins, k), model(ins, k));
         bus.instr_valid = ($urandom_range(0, 1) == 1);
         bus.instr       = $urandom;
         if (k == upto) bus.instr_valid = 1'b0;
         if (k < upto) @(negedge clk);
      end
      if (upto == n) begin
         if (n == 4) exp_retired++;
         else exp_illegal++;
      end
   endtask

   task automatic offer(input logic [31:0] ins, input int gap);
      for (int g = 0; g < gap; g++) begin
         @(negedge clk);
         bus.instr = $urandom;
         check("idle gap", model(last_ins, 0));
      end
      @(negedge clk);
      check($sformatf("idle before %h", ins), model(last_ins, 0));
      check_cnt("perf counters");
      bus.instr_valid = 1'b1;
      bus.instr       = ins;
      @(negedge clk);
      last_ins = ins;
   endtask

   task automatic run_instr(input logic [31:0] ins, input int gap);
      offer(ins, gap);
      run_steps(ins, is_legal(ins) ? 4 : 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] w;
      bus.instr_valid = 1'b1;
      bus.instr       = 32'h00040413;
      repeat (3) begin
         @(negedge clk);
         check("reset hold", model(32'd0, 0));
         check_cnt("reset counters");
      end
      reset = 1'b1;
      @(negedge clk);
      last_ins = 32'h00040413;
      run_steps(32'h00040413, 4);

      run_instr(32'h407302B3, 0);
      run_instr(32'h4030D093, 1);
      run_instr(32'h12345237, 0);
      run_instr(32'h00100013, 2);
      run_instr(32'h00000000, 0);
      run_instr(32'h00000000, 0);

      offer(32'h002081B3, 0);
      run_steps(32'h002081B3, 3);
      reset = 1'b0;
      #1;
      exp_retired = 0;
      exp_illegal = 0;
      last_ins    = 32'd0;
      check("reset in exec", model(32'd0, 0));
      check_cnt("counters after reset");
      @(negedge clk);
      check("reset held after exec", model(32'd0, 0));
      reset = 1'b1;
      run_instr(32'h002081B3, 0);

      for (int i = 0; i < 40; i++) begin
         w = $urandom;
         case ($urandom_range(0, 3))
            0: w = {w[31:7], 7'h33};
            1: w = {w[31:7], 7'h13};
            2: w = {w[31:7], 7'h37};
            default: ;
         endcase
         run_instr(w, $urandom_range(0, 2));
      end

      @(negedge clk);
      check("final idle", model(last_ins, 0));
      check_cnt("final counters");
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
